// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan of a 4-digit 7-segment display.
// Latches a 16-bit hex value, DP/enable masks and a brightness code at each
// frame start. It then scans digit1..digit4. Each digit slot is a blanking
// dead-time followed by a 16-step PWM drive window.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   en         1: scan runs; 0: display dark, scheduler parked at frame start
//   value      hex value, [15:12] -> digit1 ... [3:0] -> digit4
//   dp_mask    decimal point per digit, bit3 -> digit1 ... bit0 -> digit4
//   digit_en   digit visible per digit, bit3 -> digit1 ... bit0 -> digit4
//   bright     digit lit for (bright+1)/16 of its drive slot
//   seg        {a,b,c,d,e,f,g,dp} from MSB to LSB, polarity per SEG_ACT_LOW
//   digit1..4  digit selects, polarity per DIG_ACT_LOW, at most one active
//   frame_tick one-cycle pulse for the cycle in which inputs are latched
module seg_scan_controller #(
  parameter int unsigned SUB_CYCLES   = 3125,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          DIG_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  bright,
  output logic [7:0]  seg,
  output logic        digit1,
  output logic        digit2,
  output logic        digit3,
  output logic        digit4,
  output logic        frame_tick
);

  localparam int unsigned CNT_MAX    = (SUB_CYCLES > BLANK_CYCLES) ? SUB_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(SUB_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic       DIG_OFF = DIG_ACT_LOW ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       sub, sub_nxt;

  logic [15:0] value_l;
  logic [3:0]  dp_l, den_l, bright_l;

  logic       frame_start_c;
  logic       lit_c;
  logic [3:0] nib_c;
  logic       dp_bit_c, den_bit_c;
  logic [6:0] glyph_c;
  logic [7:0] seg_on_c, seg_nxt_c;
  logic [3:0] sel_c, dig_nxt_c;

  // State register and frame-start input latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BLANK;
      idx      <= 2'd0;
      cnt      <= '0;
      sub      <= 4'd0;
      value_l  <= 16'd0;
      dp_l     <= 4'd0;
      den_l    <= 4'd0;
      bright_l <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      sub   <= sub_nxt;
      if (frame_start_c) begin
        value_l  <= value;
        dp_l     <= dp_mask;
        den_l    <= digit_en;
        bright_l <= bright;
      end
    end
  end

  // Next-state: blank dead-time, then 16 PWM sub-steps per digit slot
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    sub_nxt       = sub;
    frame_start_c = en && (state == ST_BLANK) && (idx == 2'd0) && (cnt == '0);
    if (!en) begin
      state_nxt = ST_BLANK;
      idx_nxt   = 2'd0;
      cnt_nxt   = '0;
      sub_nxt   = 4'd0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = ST_DRIVE;
            cnt_nxt   = '0;
            sub_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt == SUB_LAST) begin
            cnt_nxt = '0;
            if (sub == 4'd15) begin
              sub_nxt   = 4'd0;
              idx_nxt   = idx + 2'd1;
              state_nxt = ST_BLANK;
            end else begin
              sub_nxt = sub + 4'd1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_BLANK;
      endcase
    end
  end

  // Per-slot selection of nibble and mask bits (idx 0 is digit1, the MSB side)
  always_comb begin
    nib_c     = value_l[15:12];
    dp_bit_c  = dp_l[3];
    den_bit_c = den_l[3];
    case (idx)
      2'd0: begin nib_c = value_l[15:12]; dp_bit_c = dp_l[3]; den_bit_c = den_l[3]; end
      2'd1: begin nib_c = value_l[11:8];  dp_bit_c = dp_l[2]; den_bit_c = den_l[2]; end
      2'd2: begin nib_c = value_l[7:4];   dp_bit_c = dp_l[1]; den_bit_c = den_l[1]; end
      default: begin nib_c = value_l[3:0]; dp_bit_c = dp_l[0]; den_bit_c = den_l[0]; end
    endcase
  end

  // Hex glyphs, active-high, {a,b,c,d,e,f,g}
  always_comb begin
    glyph_c = 7'b0000000;
    case (nib_c)
      4'h0: glyph_c = 7'b1111110;
      4'h1: glyph_c = 7'b0110000;
      4'h2: glyph_c = 7'b1101101;
      4'h3: glyph_c = 7'b1111001;
      4'h4: glyph_c = 7'b0110011;
      4'h5: glyph_c = 7'b1011011;
      4'h6: glyph_c = 7'b1011111;
      4'h7: glyph_c = 7'b1110000;
      4'h8: glyph_c = 7'b1111111;
      4'h9: glyph_c = 7'b1111011;
      4'hA: glyph_c = 7'b1110111;
      4'hB: glyph_c = 7'b0011111;
      4'hC: glyph_c = 7'b1001110;
      4'hD: glyph_c = 7'b0111101;
      4'hE: glyph_c = 7'b1001111;
      default: glyph_c = 7'b1000111;
    endcase
  end

  // Output decode, registered below for a fixed one-cycle lag
  always_comb begin
    lit_c     = en && (state == ST_DRIVE) && den_bit_c && (sub <= bright_l);
    seg_on_c  = {glyph_c, dp_bit_c};
    seg_nxt_c = SEG_OFF;
    sel_c     = 4'b0000;
    if (lit_c) begin
      seg_nxt_c = SEG_ACT_LOW ? ~seg_on_c : seg_on_c;
      sel_c     = 4'b1000 >> idx;
    end
    dig_nxt_c = DIG_ACT_LOW ? ~sel_c : sel_c;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg        <= SEG_OFF;
      digit1     <= DIG_OFF;
      digit2     <= DIG_OFF;
      digit3     <= DIG_OFF;
      digit4     <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt_c;
      digit1     <= dig_nxt_c[3];
      digit2     <= dig_nxt_c[2];
      digit3     <= dig_nxt_c[1];
      digit4     <= dig_nxt_c[0];
      frame_tick <= frame_start_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with SUB_CYCLES=2, BLANK_CYCLES=3, active-low.
// A frame-position model pushes the expected outputs into a queue each cycle,
// and the bench pops and compares them after the edge. A vector table checks
// the lit cycles per digit over whole frames. Hand sequences cover reset,
// enable and mid-frame input changes.
module tb_seg_scan_controller;

  localparam int SUB   = 2;
  localparam int BLANK = 3;
  localparam int SLOT  = BLANK + 16 * SUB;  // 35
  localparam int FRAME = 4 * SLOT;          // 140

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] value;
  logic [3:0]  dp_mask, digit_en, bright;
  logic [7:0]  seg;
  logic        digit1, digit2, digit3, digit4, frame_tick;

  seg_scan_controller #(
    .SUB_CYCLES(SUB), .BLANK_CYCLES(BLANK), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_mask(dp_mask),
    .digit_en(digit_en), .bright(bright), .seg(seg), .digit1(digit1),
    .digit2(digit2), .digit3(digit3), .digit4(digit4), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;   // {digit1..digit4} pin levels
    logic       tick;
  } exp_t;

  localparam exp_t OFF = '{seg: 8'hFF, dig: 4'hF, tick: 1'b0};

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      den;
    logic [3:0]      bright;
    int              frames;
    logic [3:0][7:0] exp_on;  // [3] = digit1 ... [0] = digit4
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  int          m_pos = 0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_dp = '0, m_den = '0, m_bright = '0;

  int   on_cnt[4];
  int   tick_cnt = 0;
  logic [3:0] prev_act = '0;
  int   off_run = 0;
  bit   seen_act = 1'b0;

  // Active-low glyphs {a..g}
  function automatic logic [6:0] glyph_al(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001; 4'h1: return 7'b1001111;
      4'h2: return 7'b0010010; 4'h3: return 7'b0000110;
      4'h4: return 7'b1001100; 4'h5: return 7'b0100100;
      4'h6: return 7'b0100000; 4'h7: return 7'b0001111;
      4'h8: return 7'b0000000; 4'h9: return 7'b0000100;
      4'hA: return 7'b0001000; 4'hB: return 7'b1100000;
      4'hC: return 7'b0110001; 4'hD: return 7'b1000010;
      4'hE: return 7'b0110000; default: return 7'b0111000;
    endcase
  endfunction

  function automatic exp_t model_out(input int p);
    exp_t e;
    int slot, off, s, b;
    logic [3:0] nib;
    logic [15:0] v;
    e = OFF;
    e.tick = (p == 0);
    slot = p / SLOT;
    off  = p % SLOT;
    b    = 3 - slot;
    if (off >= BLANK) begin
      s = (off - BLANK) / SUB;
      if (m_den[b] && (s <= int'(m_bright))) begin
        v = m_value >> (4 * b);
        nib = v[3:0];
        e.seg = {glyph_al(nib), ~m_dp[b]};
        e.dig = ~(4'b0001 << b);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock per iteration: predict, push, clock, pop and compare, invariants
  task automatic step(input int n);
    exp_t e, got;
    logic [3:0] act;
    for (int i = 0; i < n; i++) begin
      if (!rst) begin
        e = OFF; m_pos = 0;
        m_value = '0; m_dp = '0; m_den = '0; m_bright = '0;
      end else if (!en) begin
        e = OFF; m_pos = 0;
      end else begin
        if (m_pos == 0) begin
          m_value = value; m_dp = dp_mask; m_den = digit_en; m_bright = bright;
        end
        e = model_out(m_pos);
        m_pos = (m_pos + 1) % FRAME;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = '{seg: seg, dig: {digit1, digit2, digit3, digit4}, tick: frame_tick};
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("scoreboard", 32'(got), 32'(e));
      end
      act = ~got.dig;
      chk("one_digit_max", 32'($countones(act) <= 1), 32'd1);
      if (act != 4'b0 && act != prev_act) begin
        chk("blank_gap", 32'(prev_act == 4'b0 && (!seen_act || off_run >= 3)), 32'd1);
      end
      if (act == 4'b0) off_run++;
      else begin off_run = 0; seen_act = 1'b1; end
      prev_act = act;
      for (int k = 0; k < 4; k++) if (act[k]) on_cnt[k]++;
      if (got.tick) tick_cnt++;
    end
  endtask

  task automatic step_until_tick(input int budget, output int n);
    n = 0;
    do begin step(1); n++; end while (frame_tick !== 1'b1 && n < budget);
    if (frame_tick !== 1'b1) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  // b: 3 = digit1 ... 0 = digit4
  task automatic step_until_digit(input int b, input int budget);
    int n;
    logic [3:0] d;
    n = 0;
    do begin
      step(1); n++;
      d = {digit1, digit2, digit3, digit4};
    end while (d[b] !== 1'b0 && n < budget);
    if (d[b] !== 1'b0) chk("digit_timeout", 32'd0, 32'd1);
  endtask

  task automatic restart_frame();
    en = 1'b0; step(1); en = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{16'h1208, 4'hF, 4'hF, 4'd15, 1, {8'd32, 8'd32, 8'd32, 8'd32}};
    vecs[1] = '{16'h4A7C, 4'h5, 4'hF, 4'd0,  1, {8'd2,  8'd2,  8'd2,  8'd2}};
    vecs[2] = '{16'h9E3B, 4'hA, 4'hF, 4'd7,  1, {8'd16, 8'd16, 8'd16, 8'd16}};
    vecs[3] = '{16'h5D60, 4'hF, 4'b1011, 4'd15, 3, {8'd96, 8'd0, 8'd96, 8'd96}};
    vecs[4] = '{16'hC0F1, 4'h0, 4'b0101, 4'd3,  1, {8'd0, 8'd8, 8'd0, 8'd8}};

    rst = 1'b0; en = 1'b1; value = 16'h1208;
    dp_mask = 4'hF; digit_en = 4'hF; bright = 4'd15;
    for (int k = 0; k < 4; k++) on_cnt[k] = 0;

    // Reset, release, first frame
    step(3);
    chk("reset_outputs", 32'({seg, digit1, digit2, digit3, digit4, frame_tick}), 32'({8'hFF, 4'hF, 1'b0}));
    rst = 1'b1;
    step(1);
    chk("first_tick", 32'(frame_tick), 32'd1);
    step(2);
    chk("dead_time", 32'({digit1, digit2, digit3, digit4}), 32'hF);
    step(1);
    chk("digit1_on", 32'({digit1, digit2, digit3, digit4}), 32'b0111);
    chk("seg_1_dp", 32'(seg), 32'b1001_1110);
    step_until_tick(300, n);
    chk("frame_period", 32'(n), 32'(FRAME - 3));

    // Table: lit cycles per digit over whole frames
    for (int r = 0; r < 5; r++) begin
      value = vecs[r].value; dp_mask = vecs[r].dp;
      digit_en = vecs[r].den; bright = vecs[r].bright;
      restart_frame();
      for (int k = 0; k < 4; k++) on_cnt[k] = 0;
      tick_cnt = 0;
      step(FRAME * vecs[r].frames);
      for (int k = 0; k < 4; k++)
        chk($sformatf("vec%0d_on_cycles_d%0d", r, 4 - k), 32'(on_cnt[k]), 32'(vecs[r].exp_on[k]));
      chk($sformatf("vec%0d_ticks", r), 32'(tick_cnt), 32'(vecs[r].frames));
    end

    // Mid-frame value change holds until next frame start
    value = 16'h0000; dp_mask = 4'h0; digit_en = 4'hF; bright = 4'd15;
    restart_frame();
    step(50);
    value = 16'hFFFF;
    step_until_digit(1, 100);
    chk("old_value_held", 32'(seg), 32'b0000_0011);
    step_until_tick(300, n);
    step_until_digit(3, 50);
    chk("new_value_F", 32'(seg), 32'b0111_0001);

    // Async reset mid-drive
    value = 16'h1208; dp_mask = 4'hF;
    restart_frame();
    step(10);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_off", 32'({seg, digit1, digit2, digit3, digit4, frame_tick}), 32'({8'hFF, 4'hF, 1'b0}));
    step(2);
    rst = 1'b1;
    step(1);
    chk("tick_after_reset", 32'(frame_tick), 32'd1);
    step(3);
    chk("digit1_after_reset", 32'(digit1), 32'd0);

    // en low for 5 cycles mid-drive
    step(20);
    en = 1'b0;
    step(1);
    chk("en_low_off", 32'({seg, digit1, digit2, digit3, digit4, frame_tick}), 32'({8'hFF, 4'hF, 1'b0}));
    step(4);
    en = 1'b1;
    step(1);
    chk("tick_after_en", 32'(frame_tick), 32'd1);
    step(3);
    chk("digit1_after_en", 32'(digit1), 32'd0);
    step(FRAME);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
